// File: rtl/bcd2bin_seq_if.sv
// bcd2bin_seq_if: request/result bundle for the
// sequential BCD-to-binary converter.
interface bcd2bin_seq_if;
  logic        start;
  logic [11:0] bcd_in;
  logic [9:0]  bin_out;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output start,
    output bcd_in,
    input  bin_out,
    input  busy,
    input  done,
    input  err
  );

  modport slave (
    input  start,
    input  bcd_in,
    output bin_out,
    output busy,
    output done,
    output err
  );
endinterface

// File: rtl/bcd2bin_seq.sv
// bcd2bin_seq: 3-digit BCD to 10-bit binary via
// reverse double-dabble, one bit per SHIFT cycle.
module bcd2bin_seq (
  input  logic         clk,
  input  logic         rst,
  bcd2bin_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [11:0] r_bcd;
  logic [9:0]  r_bin;
  logic [3:0]  r_cnt;
  logic        r_err_pend;
  logic [9:0]  r_bin_out;
  logic        r_err;
  logic        r_done;

  logic        w_accept;
  logic        w_bad;
  logic        w_last;
  logic        w_busy;
  logic        w_load;
  logic [21:0] w_cat;
  logic [11:0] w_bcd_adj;

  function automatic logic [3:0] adj3(
    input logic [3:0] d
  );
    return (d >= 4'd8) ? d - 4'd3 : d;
  endfunction

  // The done cycle is not an accept slot: the
  // request seen alongside done belongs to FINISH.
  assign w_accept = (r_state == IDLE)
                  && bus.start && !r_done;
  assign w_bad = (bus.bcd_in[3:0]  > 4'd9)
              || (bus.bcd_in[7:4]  > 4'd9)
              || (bus.bcd_in[11:8] > 4'd9);
  assign w_last = (r_cnt == 4'd9);
  assign w_cat = {r_bcd, r_bin} >> 1;
  assign w_bcd_adj = {adj3(w_cat[21:18]),
                      adj3(w_cat[17:14]),
                      adj3(w_cat[13:10])};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept)
          w_next = w_bad ? FINISH : SHIFT;
      end
      SHIFT: begin
        if (w_last) w_next = FINISH;
      end
      FINISH:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State-decoded controls
  always_comb begin
    w_busy = 1'b0;
    w_load = 1'b0;
    unique case (r_state)
      SHIFT:   w_busy = 1'b1;
      FINISH:  w_load = 1'b1;
      default: ;
    endcase
  end

  // Shift registers and iteration counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bcd      <= '0;
      r_bin      <= '0;
      r_cnt      <= '0;
      r_err_pend <= 1'b0;
    end else if (w_accept) begin
      r_bcd      <= bus.bcd_in;
      r_bin      <= '0;
      r_cnt      <= '0;
      r_err_pend <= w_bad;
    end else if (w_busy) begin
      r_bcd <= w_bcd_adj;
      r_bin <= w_cat[9:0];
      r_cnt <= r_cnt + 4'd1;
    end
  end

  // Result registers, loaded only on FINISH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bin_out <= '0;
      r_err     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_load;
      if (w_load) begin
        r_bin_out <= r_err_pend ? 10'd0 : r_bin;
        r_err     <= r_err_pend;
      end
    end
  end

  assign bus.bin_out = r_bin_out;
  assign bus.err     = r_err;
  assign bus.done    = r_done;
  assign bus.busy    = w_busy;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// tb_bcd2bin_seq: randomized self-checking bench
// with an arithmetic reference model.
module tb_bcd2bin_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;

  bcd2bin_seq_if bus ();

  bcd2bin_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic bit ref_err(
    input logic [11:0] b
  );
    return (int'(b[11:8]) > 9)
        || (int'(b[7:4]) > 9)
        || (int'(b[3:0]) > 9);
  endfunction

  function automatic logic [9:0] ref_bin(
    input logic [11:0] b
  );
    int v;
    if (ref_err(b)) return 10'd0;
    v = 100 * int'(b[11:8])
      + 10 * int'(b[7:4]) + int'(b[3:0]);
    return 10'(v);
  endfunction

  // Runs one request and reports what was seen.
  task automatic do_conv(
    input  logic [11:0] b,
    input  bit          noise,
    input  bit          chain,
    input  logic [11:0] nb,
    output int          lat,
    output int          bcnt,
    output int          ovl,
    output bit          held,
    output bit          pulse1,
    output logic [9:0]  bo,
    output logic        e
  );
    logic [9:0] prev;
    lat = -1;
    bcnt = 0;
    ovl = 0;
    held = 1'b1;
    pulse1 = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.bcd_in = b;
    prev = bus.bin_out;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.bcd_in = 12'($urandom);
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (bus.busy === 1'b1) bcnt++;
      if (bus.busy === 1'b1 && bus.done === 1'b1)
        ovl++;
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end
      if (bus.bin_out !== prev) held = 1'b0;
      if (noise) begin
        bus.start = 1'($urandom);
        bus.bcd_in = 12'($urandom);
      end
    end
    bo = bus.bin_out;
    e = bus.err;
    if (chain) begin
      bus.start = 1'b1;
      bus.bcd_in = nb;
    end else begin
      bus.start = 1'b0;
    end
    @(posedge clk);
    #1;
    pulse1 = (bus.done === 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    total++;
    if ({bus.bin_out, bus.err, bus.done,
         bus.busy} !== 13'd0) begin
      bad++;
      $display("FAIL reset_outs got=%h exp=0",
        {bus.bin_out, bus.err, bus.done,
         bus.busy});
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_busy got=%b exp=0",
        bus.busy);
    end
  endtask

  task automatic test_known();
    logic [11:0] tab [4];
    int lat, bc, ov, xl, xb;
    bit hd, p1;
    logic [9:0] bo;
    logic e;
    tab[0] = 12'h999;
    tab[1] = 12'h000;
    tab[2] = 12'h255;
    tab[3] = 12'h1A0;
    for (int i = 0; i < 4; i++) begin
      do_conv(tab[i], 1'b0, 1'b0, 12'h0,
        lat, bc, ov, hd, p1, bo, e);
      xl = ref_err(tab[i]) ? 1 : 11;
      xb = ref_err(tab[i]) ? 0 : 10;
      total++;
      if (lat != xl) begin
        bad++;
        $display("FAIL known_lat %h got=%0d exp=%0d",
          tab[i], lat, xl);
      end
      total++;
      if (bo !== ref_bin(tab[i])) begin
        bad++;
        $display("FAIL known_bin %h got=%0d exp=%0d",
          tab[i], bo, ref_bin(tab[i]));
      end
      total++;
      if (e !== ref_err(tab[i])) begin
        bad++;
        $display("FAIL known_err %h got=%b exp=%b",
          tab[i], e, ref_err(tab[i]));
      end
      total++;
      if (bc != xb) begin
        bad++;
        $display("FAIL known_busy %h got=%0d exp=%0d",
          tab[i], bc, xb);
      end
      total++;
      if (!p1 || ov != 0 || !hd) begin
        bad++;
        $display("FAIL known_pulse %h p1=%b ov=%0d hd=%b exp=1/0/1",
          tab[i], p1, ov, hd);
      end
    end
  endtask

  task automatic test_ignore();
    int lat, bc, ov;
    bit hd, p1;
    logic [9:0] bo;
    logic e;
    do_conv(12'h123, 1'b1, 1'b0, 12'h0,
      lat, bc, ov, hd, p1, bo, e);
    total++;
    if (lat != 11 || bo !== 10'd123 || !p1) begin
      bad++;
      $display("FAIL ignore_123 lat=%0d bin=%0d p1=%b exp=11/123/1",
        lat, bo, p1);
    end
    do_conv(12'h456, 1'b0, 1'b0, 12'h0,
      lat, bc, ov, hd, p1, bo, e);
    total++;
    if (lat != 11 || bo !== 10'd456) begin
      bad++;
      $display("FAIL ignore_456 lat=%0d bin=%0d exp=11/456",
        lat, bo);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc, ov;
    bit hd, p1;
    logic [9:0] bo;
    logic e;
    do_conv(12'h321, 1'b0, 1'b1, 12'h678,
      lat, bc, ov, hd, p1, bo, e);
    total++;
    if (lat != 11 || bo !== 10'd321) begin
      bad++;
      $display("FAIL b2b_first lat=%0d bin=%0d exp=11/321",
        lat, bo);
    end
    do_conv(12'h678, 1'b0, 1'b0, 12'h0,
      lat, bc, ov, hd, p1, bo, e);
    total++;
    if (lat != 11 || bo !== 10'd678) begin
      bad++;
      $display("FAIL b2b_second lat=%0d bin=%0d exp=11/678",
        lat, bo);
    end
  endtask

  task automatic test_abort();
    int lat, bc, ov, nd;
    bit hd, p1, chg;
    logic [9:0] bo;
    logic e;
    do_conv(12'h777, 1'b0, 1'b0, 12'h0,
      lat, bc, ov, hd, p1, bo, e);
    @(negedge clk);
    bus.start = 1'b1;
    bus.bcd_in = 12'h999;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if ({bus.bin_out, bus.err, bus.done,
         bus.busy} !== 13'd0) begin
      bad++;
      $display("FAIL abort_outs got=%h exp=0",
        {bus.bin_out, bus.err, bus.done,
         bus.busy});
    end
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    chg = 1'b0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) nd++;
      if (bus.bin_out !== 10'd0) chg = 1'b1;
    end
    total++;
    if (nd != 0 || chg) begin
      bad++;
      $display("FAIL abort_quiet done=%0d chg=%b exp=0/0",
        nd, chg);
    end
    do_conv(12'h042, 1'b0, 1'b0, 12'h0,
      lat, bc, ov, hd, p1, bo, e);
    total++;
    if (lat != 11 || bo !== 10'd42) begin
      bad++;
      $display("FAIL abort_next lat=%0d bin=%0d exp=11/42",
        lat, bo);
    end
  endtask

  task automatic test_invalid_random();
    logic [11:0] b;
    int idx, lat, bc, ov;
    bit hd, p1;
    logic [9:0] bo;
    logic e;
    for (int i = 0; i < 60; i++) begin
      b = 12'($urandom);
      idx = $urandom_range(0, 2);
      b[idx*4 +: 4] = 4'($urandom_range(10, 15));
      do_conv(b, 1'b1, 1'b0, 12'h0,
        lat, bc, ov, hd, p1, bo, e);
      total++;
      if (lat != 1 || bc != 0 || e !== 1'b1
          || bo !== ref_bin(b) || !p1) begin
        bad++;
        $display("FAIL invalid %h lat=%0d busy=%0d err=%b bin=%0d exp=1/0/1/0",
          b, lat, bc, e, bo);
      end
    end
  endtask

  task automatic test_sweep();
    logic [11:0] b;
    int lat, bc, ov;
    bit hd, p1;
    logic [9:0] bo;
    logic e;
    for (int v = 0; v < 1000; v++) begin
      b = {4'(v / 100), 4'((v / 10) % 10),
           4'(v % 10)};
      do_conv(b, 1'($urandom), 1'b0, 12'h0,
        lat, bc, ov, hd, p1, bo, e);
      total++;
      if (lat != 11 || bo !== ref_bin(b)
          || e !== 1'b0 || bc != 10
          || ov != 0 || !p1) begin
        bad++;
        $display("FAIL sweep %h lat=%0d bin=%0d err=%b busy=%0d exp=11/%0d/0/10",
          b, lat, bo, e, bc, ref_bin(b));
      end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.bcd_in = 12'h000;
    #2;
    test_reset();
    test_known();
    test_ignore();
    test_back_to_back();
    test_abort();
    test_invalid_random();
    test_sweep();
    $display("test done: total=%0d bad=%0d",
      total, bad);
    $finish;
  end

endmodule
